// File: rtl/dht_bcd_formatter_pkg.sv
// Shared definitions for the DHT reading formatter.
// Provides the FSM state encoding, the BCD result width, the decimal-digit
// clamp value, the default stale period (same value as the DHT controller
// autostart period) and small helper functions used by the datapath.
package dht_bcd_formatter_pkg;

  localparam int unsigned BCD_W           = 12;
  localparam int unsigned DIGIT_MAX       = 9;
  localparam int unsigned STALE_TICKS_DEF = 300_000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_UPD  = 2'd2
  } state_e;

  // A decimal byte above 9 cannot be shown as one digit; pin it to 9.
  function automatic logic [3:0] clamp_digit(input logic [7:0] b);
    if (b > 8'(DIGIT_MAX)) begin
      return 4'(DIGIT_MAX);
    end
    return b[3:0];
  endfunction

  // Double-dabble correction for one BCD nibble.
  function automatic logic [3:0] add3_ge5(input logic [3:0] n);
    return (n >= 4'd5) ? (n + 4'd3) : n;
  endfunction

endpackage

// File: rtl/dht_bcd_formatter_bcd_dd_step.sv
// One combinational double-dabble step for an 8-bit lane.
// Ports:
//   i_bcd  current 3-digit BCD accumulator {hundreds,tens,ones}
//   i_bit  next MSB shifted in from the binary work byte
//   o_bcd  accumulator after add-3 correction and one-bit left shift
module dht_bcd_formatter_bcd_dd_step
  import dht_bcd_formatter_pkg::*;
(
  input  logic [BCD_W-1:0] i_bcd,
  input  logic             i_bit,
  output logic [BCD_W-1:0] o_bcd
);

  logic [BCD_W-1:0] w_adj;
  logic             w_unused_msb;

  always_comb begin
    w_adj = {add3_ge5(i_bcd[11:8]), add3_ge5(i_bcd[7:4]), add3_ge5(i_bcd[3:0])};
    o_bcd = {w_adj[BCD_W-2:0], i_bit};
  end

  // An 8-bit input never pushes a set bit out of the hundreds nibble.
  assign w_unused_msb = w_adj[BCD_W-1];

endmodule

// File: rtl/dht_bcd_formatter.sv
// DHT reading formatter.
// Latches a DHT result on iDone, converts the humidity and temperature
// integer bytes to 3-digit BCD (sequential double-dabble, 8 clocks), clamps
// the decimal bytes to one digit and publishes a stable snapshot with a
// one-cycle oValid pulse. A one-entry pending buffer holds the latest reading
// that arrives while busy. A 10 us tick watchdog flags stale data.
// Ports:
//   iClk, iRst_n            clock, asynchronous active-low reset
//   iTick_10us              one-cycle 10 us tick
//   iDone                   one-cycle pulse, result bytes valid
//   iHumid_Int/Dec, iTemp_Int/Dec  result bytes
//   oHumid_BCD, oTemp_BCD   integer parts, BCD {hundreds,tens,ones}
//   oHumid_DecD, oTemp_DecD decimal digits 0-9
//   oValid                  one-cycle pulse on every output update
//   oBusy                   conversion or update in progress
//   oStale                  no fresh published reading within STALE_TICKS
//   oUpdCnt                 completed update count, wraps at 256
module dht_bcd_formatter
  import dht_bcd_formatter_pkg::*;
#(
  parameter int unsigned STALE_TICKS = STALE_TICKS_DEF,
  parameter int unsigned STALE_W     = $clog2(STALE_TICKS + 1)
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iTick_10us,
  input  logic             iDone,
  input  logic [7:0]       iHumid_Int,
  input  logic [7:0]       iHumid_Dec,
  input  logic [7:0]       iTemp_Int,
  input  logic [7:0]       iTemp_Dec,
  output logic [BCD_W-1:0] oHumid_BCD,
  output logic [3:0]       oHumid_DecD,
  output logic [BCD_W-1:0] oTemp_BCD,
  output logic [3:0]       oTemp_DecD,
  output logic             oValid,
  output logic             oBusy,
  output logic             oStale,
  output logic [7:0]       oUpdCnt
);

  state_e r_state, w_state_next;

  // Conversion work registers
  logic [2:0]       r_shift_cnt;
  logic [7:0]       r_h_work, r_t_work;
  logic [BCD_W-1:0] r_h_acc, r_t_acc;
  logic [3:0]       r_h_dec_work, r_t_dec_work;

  // One-entry pending buffer (latest reading wins)
  logic             r_pend;
  logic [7:0]       r_pend_h_int, r_pend_t_int;
  logic [3:0]       r_pend_h_dec, r_pend_t_dec;

  // Published snapshot
  logic [BCD_W-1:0] r_h_bcd, r_t_bcd;
  logic [3:0]       r_h_dec, r_t_dec;
  logic             r_valid;
  logic [7:0]       r_upd_cnt;

  // Watchdog
  logic [STALE_W-1:0] r_stale_cnt;
  logic               r_fresh;
  logic               w_stale_sat;

  // FSM strobes
  logic w_load_new, w_load_pend, w_pend_wr, w_publish, w_step;

  logic [BCD_W-1:0] w_h_step, w_t_step;

  dht_bcd_formatter_bcd_dd_step u_step_h (
    .i_bcd (r_h_acc),
    .i_bit (r_h_work[7]),
    .o_bcd (w_h_step)
  );

  dht_bcd_formatter_bcd_dd_step u_step_t (
    .i_bcd (r_t_acc),
    .i_bit (r_t_work[7]),
    .o_bcd (w_t_step)
  );

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load_new   = 1'b0;
    w_load_pend  = 1'b0;
    w_pend_wr    = 1'b0;
    w_publish    = 1'b0;
    w_step       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (iDone) begin
          w_load_new   = 1'b1;
          w_state_next = S_CONV;
        end
      end
      S_CONV: begin
        w_step    = 1'b1;
        w_pend_wr = iDone;
        if (r_shift_cnt == 3'd7) begin
          w_state_next = S_UPD;
        end
      end
      S_UPD: begin
        w_publish = 1'b1;
        if (r_pend) begin
          // Buffered reading is consumed; a simultaneous iDone refills it.
          w_load_pend  = 1'b1;
          w_pend_wr    = iDone;
          w_state_next = S_CONV;
        end else if (iDone) begin
          // Nothing buffered, so the new reading can start straight away.
          w_load_new   = 1'b1;
          w_state_next = S_CONV;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_shift_cnt  <= '0;
      r_h_work     <= '0;
      r_t_work     <= '0;
      r_h_acc      <= '0;
      r_t_acc      <= '0;
      r_h_dec_work <= '0;
      r_t_dec_work <= '0;
    end else if (w_load_new) begin
      r_shift_cnt  <= '0;
      r_h_work     <= iHumid_Int;
      r_t_work     <= iTemp_Int;
      r_h_acc      <= '0;
      r_t_acc      <= '0;
      r_h_dec_work <= clamp_digit(iHumid_Dec);
      r_t_dec_work <= clamp_digit(iTemp_Dec);
    end else if (w_load_pend) begin
      r_shift_cnt  <= '0;
      r_h_work     <= r_pend_h_int;
      r_t_work     <= r_pend_t_int;
      r_h_acc      <= '0;
      r_t_acc      <= '0;
      r_h_dec_work <= r_pend_h_dec;
      r_t_dec_work <= r_pend_t_dec;
    end else if (w_step) begin
      r_shift_cnt <= r_shift_cnt + 3'd1;
      r_h_work    <= {r_h_work[6:0], 1'b0};
      r_t_work    <= {r_t_work[6:0], 1'b0};
      r_h_acc     <= w_h_step;
      r_t_acc     <= w_t_step;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_pend       <= 1'b0;
      r_pend_h_int <= '0;
      r_pend_t_int <= '0;
      r_pend_h_dec <= '0;
      r_pend_t_dec <= '0;
    end else if (w_pend_wr) begin
      r_pend       <= 1'b1;
      r_pend_h_int <= iHumid_Int;
      r_pend_t_int <= iTemp_Int;
      r_pend_h_dec <= clamp_digit(iHumid_Dec);
      r_pend_t_dec <= clamp_digit(iTemp_Dec);
    end else if (w_load_pend) begin
      r_pend <= 1'b0;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_h_bcd   <= '0;
      r_t_bcd   <= '0;
      r_h_dec   <= '0;
      r_t_dec   <= '0;
      r_valid   <= 1'b0;
      r_upd_cnt <= '0;
    end else begin
      r_valid <= w_publish;
      if (w_publish) begin
        r_h_bcd   <= r_h_acc;
        r_t_bcd   <= r_t_acc;
        r_h_dec   <= r_h_dec_work;
        r_t_dec   <= r_t_dec_work;
        r_upd_cnt <= r_upd_cnt + 8'd1;
      end
    end
  end

  assign w_stale_sat = (r_stale_cnt == STALE_W'(STALE_TICKS));

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_stale_cnt <= '0;
      r_fresh     <= 1'b0;
    end else begin
      // A new reading restarts the watchdog even if a tick lands with it.
      if (iDone) begin
        r_stale_cnt <= '0;
      end else if (iTick_10us && !w_stale_sat) begin
        r_stale_cnt <= r_stale_cnt + STALE_W'(1);
      end
      // Freshness returns only once a reading has actually been published.
      if (w_stale_sat) begin
        r_fresh <= 1'b0;
      end else if (w_publish) begin
        r_fresh <= 1'b1;
      end
    end
  end

  assign oHumid_BCD  = r_h_bcd;
  assign oTemp_BCD   = r_t_bcd;
  assign oHumid_DecD = r_h_dec;
  assign oTemp_DecD  = r_t_dec;
  assign oValid      = r_valid;
  assign oUpdCnt     = r_upd_cnt;
  assign oBusy       = (r_state != S_IDLE);
  assign oStale      = w_stale_sat | ~r_fresh;

endmodule

// File: tb/tb_dht_bcd_formatter.sv
module tb_dht_bcd_formatter;

  localparam int StaleTicks = 10;

  logic        iClk = 1'b0;
  logic        iRst_n;
  logic        iTick_10us;
  logic        iDone;
  logic [7:0]  iHumid_Int, iHumid_Dec, iTemp_Int, iTemp_Dec;
  logic [11:0] oHumid_BCD, oTemp_BCD;
  logic [3:0]  oHumid_DecD, oTemp_DecD;
  logic        oValid, oBusy, oStale;
  logic [7:0]  oUpdCnt;

  always #5 iClk = ~iClk;

  dht_bcd_formatter #(.STALE_TICKS(StaleTicks)) u_dut (
    .iClk        (iClk),
    .iRst_n      (iRst_n),
    .iTick_10us  (iTick_10us),
    .iDone       (iDone),
    .iHumid_Int  (iHumid_Int),
    .iHumid_Dec  (iHumid_Dec),
    .iTemp_Int   (iTemp_Int),
    .iTemp_Dec   (iTemp_Dec),
    .oHumid_BCD  (oHumid_BCD),
    .oHumid_DecD (oHumid_DecD),
    .oTemp_BCD   (oTemp_BCD),
    .oTemp_DecD  (oTemp_DecD),
    .oValid      (oValid),
    .oBusy       (oBusy),
    .oStale      (oStale),
    .oUpdCnt     (oUpdCnt)
  );

  typedef struct {
    int          edge_n;
    logic [11:0] h_bcd;
    logic [3:0]  h_dec;
    logic [11:0] t_bcd;
    logic [3:0]  t_dec;
    logic [7:0]  cnt;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state (transaction level)
  int   e         = 0;
  int   pub_edge  = 0;
  bit   inflight  = 0;
  bit   pend_v    = 0;
  exp_t pend_rec;
  exp_t cur_rec;
  exp_t new_rec;
  int   m_cnt     = 0;
  int   stale_cnt = 0;
  bit   fresh     = 0;
  bit   pub_now;
  exp_t held;

  function automatic logic [11:0] to_bcd(input int v);
    logic [3:0] d2, d1, d0;
    d2 = 4'(v / 100);
    d1 = 4'((v / 10) % 10);
    d0 = 4'(v % 10);
    return {d2, d1, d0};
  endfunction

  function automatic logic [3:0] clamp9(input int d);
    return (d > 9) ? 4'd9 : 4'(d);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic schedule(input exp_t r);
    exp_t s;
    s        = r;
    m_cnt    = (m_cnt + 1) % 256;
    s.cnt    = 8'(m_cnt);
    s.edge_n = e + 9;
    pub_edge = e + 9;
    cur_rec  = s;
    inflight = 1;
    exp_q.push_back(s);
  endtask

  // Model: reading enters a one-deep pipeline; publication 9 edges after start.
  always @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      exp_q.delete();
      inflight  = 0;
      pend_v    = 0;
      m_cnt     = 0;
      stale_cnt = 0;
      fresh     = 0;
      held      = '{0, 12'h0, 4'h0, 12'h0, 4'h0, 8'h0};
    end else begin
      e++;
      pub_now = inflight && (e == pub_edge);
      if (stale_cnt == StaleTicks) fresh = 0;
      else if (pub_now) fresh = 1;
      if (pub_now) begin
        held     = cur_rec;
        inflight = 0;
        if (pend_v) begin
          pend_v = 0;
          schedule(pend_rec);
        end
      end
      if (iDone) begin
        new_rec = '{0, to_bcd(int'(iHumid_Int)), clamp9(int'(iHumid_Dec)),
                    to_bcd(int'(iTemp_Int)), clamp9(int'(iTemp_Dec)), 8'h0};
        if (!inflight) schedule(new_rec);
        else begin
          pend_rec = new_rec;
          pend_v   = 1;
        end
        stale_cnt = 0;
      end else if (iTick_10us && stale_cnt < StaleTicks) begin
        stale_cnt++;
      end
    end
  end

  // Monitor: pops the scoreboard on every oValid, checks held state each cycle.
  always @(negedge iClk) begin
    exp_t r;
    if (oValid) begin
      if (exp_q.size() == 0) begin
        check("valid_unexpected", 32'(oValid), 32'd0);
      end else begin
        r = exp_q.pop_front();
        check("valid_edge",  32'(e),           32'(r.edge_n));
        check("pub_h_bcd",   32'(oHumid_BCD),  32'(r.h_bcd));
        check("pub_h_dec",   32'(oHumid_DecD), 32'(r.h_dec));
        check("pub_t_bcd",   32'(oTemp_BCD),   32'(r.t_bcd));
        check("pub_t_dec",   32'(oTemp_DecD),  32'(r.t_dec));
        check("pub_upd_cnt", 32'(oUpdCnt),     32'(r.cnt));
      end
    end else if (exp_q.size() != 0 && exp_q[0].edge_n <= e) begin
      r = exp_q.pop_front();
      check("valid_missing", 32'(oValid), 32'd1);
    end
    check("hold_h_bcd", 32'(oHumid_BCD),  32'(held.h_bcd));
    check("hold_t_bcd", 32'(oTemp_BCD),   32'(held.t_bcd));
    check("hold_h_dec", 32'(oHumid_DecD), 32'(held.h_dec));
    check("hold_t_dec", 32'(oTemp_DecD),  32'(held.t_dec));
    check("hold_cnt",   32'(oUpdCnt),     32'(held.cnt));
    check("busy",       32'(oBusy),       32'(inflight));
    check("stale",      32'(oStale),      32'(!fresh || stale_cnt == StaleTicks));
  end

  task automatic drive(input bit d, input int h, input int hd, input int t, input int td,
                       input bit tick);
    iDone      = d;
    iHumid_Int = 8'(h);
    iHumid_Dec = 8'(hd);
    iTemp_Int  = 8'(t);
    iTemp_Dec  = 8'(td);
    iTick_10us = tick;
    @(posedge iClk);
    #1;
    iDone      = 1'b0;
    iTick_10us = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge iClk);
      #1;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (!oBusy && exp_q.size() == 0) break;
      idle(1);
    end
    check("drain_busy",  32'(oBusy),        32'd0);
    check("drain_queue", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    iRst_n = 1'b0; iDone = 1'b0; iTick_10us = 1'b0;
    iHumid_Int = '0; iHumid_Dec = '0; iTemp_Int = '0; iTemp_Dec = '0;
    idle(2);
    iRst_n = 1'b1;
    idle(2);
    check("rst_stale",  32'(oStale),  32'd1);
    check("rst_updcnt", 32'(oUpdCnt), 32'd0);
    check("rst_valid",  32'(oValid),  32'd0);

    // Basic conversion and boundaries
    drive(1, 45, 0, 27, 3, 0);
    idle(12);
    check("basic_stale", 32'(oStale), 32'd0);
    drive(1, 255, 0, 0, 12, 0);
    idle(12);
    check("b255_h", 32'(oHumid_BCD), 32'h255);
    check("b0_t",   32'(oTemp_BCD),  32'h000);
    check("clamp9", 32'(oTemp_DecD), 32'd9);
    drive(1, 99, 5, 100, 9, 0);
    idle(12);
    check("b99_h",  32'(oHumid_BCD), 32'h099);
    check("b100_t", 32'(oTemp_BCD),  32'h100);

    // Pending buffer: 20 is superseded by 30
    drive(1, 10, 1, 11, 2, 0);
    idle(2);
    drive(1, 20, 2, 21, 3, 0);
    idle(1);
    drive(1, 30, 3, 31, 4, 0);
    idle(25);
    check("pend_last", 32'(oHumid_BCD), 32'h030);
    check("pend_cnt",  32'(oUpdCnt),    32'd5);

    // Watchdog: 9 ticks keep fresh, 10th goes stale, next update clears it
    repeat (9) drive(0, 0, 0, 0, 0, 1);
    idle(1);
    check("stale_9", 32'(oStale), 32'd0);
    drive(0, 0, 0, 0, 0, 1);
    idle(1);
    check("stale_10", 32'(oStale), 32'd1);
    drive(1, 50, 6, 22, 7, 1);
    idle(5);
    check("stale_conv", 32'(oStale), 32'd1);
    idle(6);
    check("stale_clear", 32'(oStale), 32'd0);

    // Reset in the middle of a conversion
    drive(1, 77, 7, 66, 6, 0);
    idle(3);
    iRst_n = 1'b0;
    #2;
    check("arst_h_bcd", 32'(oHumid_BCD), 32'h0);
    check("arst_busy",  32'(oBusy),      32'd0);
    check("arst_stale", 32'(oStale),     32'd1);
    check("arst_cnt",   32'(oUpdCnt),    32'd0);
    idle(2);
    iRst_n = 1'b1;
    idle(15);
    drive(1, 123, 4, 45, 15, 0);
    idle(12);
    check("post_rst_h",   32'(oHumid_BCD), 32'h123);
    check("post_rst_cnt", 32'(oUpdCnt),    32'd1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 5) == 0, int'($urandom_range(0, 255)),
            int'($urandom_range(0, 20)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 255)), $urandom_range(0, 3) == 0);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dht_bcd_formatter.md
Name: dht_bcd_formatter

Overview:
- Consumes the four result bytes and the one-cycle done pulse from the DHT sensor controller.
- Latches a reading, converts humidity and temperature integer bytes to 3-digit BCD with a sequential double-dabble, clamps the decimal bytes to one digit, and publishes a stable, display-ready snapshot with a valid pulse.
- Tracks data freshness with a 10 us tick watchdog.
- Sits between the DHT controller and the FND/UART display mux.

Parameters:
- STALE_TICKS, 300_000, number of iTick_10us ticks without a new reading before oStale asserts (3 s).
- STALE_W, $clog2(STALE_TICKS+1), width of the stale counter.

Ports:
- iClk  input  1  system clock (100 MHz).
- iRst_n  input  1  reset, asynchronous, active-low.
- iTick_10us  input  1  one-cycle 10 us tick, shared with the DHT controller.
- iDone  input  1  one-cycle pulse: result bytes valid this cycle.
- iHumid_Int  input  8  humidity integer byte.
- iHumid_Dec  input  8  humidity decimal byte.
- iTemp_Int  input  8  temperature integer byte.
- iTemp_Dec  input  8  temperature decimal byte.
- oHumid_BCD  output  12  humidity integer, BCD {hundreds,tens,ones}.
- oHumid_DecD  output  4  humidity decimal digit, 0-9.
- oTemp_BCD  output  12  temperature integer, BCD {hundreds,tens,ones}.
- oTemp_DecD  output  4  temperature decimal digit, 0-9.
- oValid  output  1  one-cycle pulse when outputs are updated.
- oBusy  output  1  conversion in progress.
- oStale  output  1  no reading within STALE_TICKS.
- oUpdCnt  output  8  count of completed updates, wraps 255 to 0.

Behaviour:
- Reset values (iRst_n low, asynchronous): all BCD/digit outputs 0, oValid 0, oBusy 0, oStale 1, oUpdCnt 0, FSM in S_IDLE, pending flag 0, stale counter 0.
- FSM states: S_IDLE, S_CONV, S_UPD.
- S_IDLE: iDone sampled high at edge N latches the four bytes into the work registers, clears the shift counter, and moves to S_CONV.
- S_CONV: one double-dabble step per clock for both bytes in parallel.
  - Each step: add 3 to every BCD nibble >= 5, then shift left one bit, bringing in the next MSB of the work byte.
  - The 3-bit shift counter runs 0..7; after the step at count 7, go to S_UPD. That is 8 clocks, edges N+1..N+8.
- S_UPD (edge N+9): register the results into the outputs, pulse oValid for exactly the following cycle, and increment oUpdCnt (mod 256).
  - Next state: S_CONV if the pending flag is set (load from the pending buffer, clear the flag), else S_IDLE.
- Latency: iDone to oValid high is exactly 9 clocks. Outputs hold their values between updates.
- oBusy = 1 in S_CONV and S_UPD.
- Decimal digits: byte > 9 clamps to 9; otherwise the low 4 bits are used. Digits are computed at latch time and published at S_UPD with the integers.
- iDone while busy: bytes go into a one-entry pending buffer and the pending flag is set. A further iDone while the flag is set overwrites the buffer (latest reading wins). Nothing is dropped silently other than superseded readings.
- iDone in S_UPD in the same cycle the pending buffer is consumed: the new bytes are written to the pending buffer and the flag stays set.
- Stale watchdog: the counter clears on every accepted iDone (IDLE or pending).
  - Otherwise it increments on iTick_10us and saturates at STALE_TICKS.
  - oStale = 1 when counter == STALE_TICKS or no update has completed since reset; it clears at the first S_UPD after a fresh reading.
  - iDone and iTick_10us in the same cycle: clear wins.
- Reset mid-conversion: immediate return to reset values. The partial result is never published and no oValid is emitted.
- Range: 0..255 converts exactly (e.g. 255 gives 0x255). No sign handling; negative temperature is not supported by the sensor variant in use.

Decomposition:
- Shared package/header: state encodings (S_IDLE=0, S_CONV=1, S_UPD=2), BCD width constant 12, digit clamp value 9, and the STALE_TICKS default shared with the DHT controller autostart period.
- One sub-module is natural: bcd_dd_step, a combinational add-3 then shift for one 8-bit double-dabble lane, instantiated twice (humidity, temperature).

Test Plan:
- Reset then idle 2 clocks: oStale=1, oUpdCnt=0, all digits 0, oValid never high.
- iDone with H=45,0 T=27,3: exactly 9 clocks later oValid=1 for one cycle, oHumid_BCD=0x045, oHumid_DecD=0, oTemp_BCD=0x027, oTemp_DecD=3, oUpdCnt=1, oStale=0.
- Boundaries: H=255, T=0, Tdec=12 gives oHumid_BCD=0x255, oTemp_BCD=0x000, oTemp_DecD=9. H=99, T=100 gives 0x099 and 0x100.
- iDone(H=10) then iDone(H=20) 3 clocks later, then iDone(H=30) 2 clocks after that: two oValid pulses, 9 clocks apart; the first shows 0x010, the second 0x030; oUpdCnt increases by 2.
- STALE_TICKS=10: after an update, 9 ticks leave oStale=0; the 10th tick sets oStale=1; the next iDone with update clears it.
- Assert iRst_n low at clock 4 of a conversion: outputs return to reset values asynchronously, no oValid follows, and the next iDone converts normally with 9-clock latency.
